// File: rtl/pair_stim_seq.sv
// Stimulus sequencer: walks {in1,in2} through four patterns per pass, strobing once per pattern.
// Optional macro PAIR_STIM_SEQ_GRAY_EN selects a Gray-coded pattern order instead of binary.
module pair_stim_seq #(
    parameter int HOLD_CYCLES = 50,
    parameter int HOLD_W      = 8,
    parameter int REPEAT      = 1,
    parameter int PASS_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              in1,
    output logic              in2,
    output logic              sample_stb,
    output logic [1:0]        pat_idx,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEAT - 1);
    localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    // Pattern index to stimulus bits; Gray order toggles a single input per step.
    function automatic logic [1:0] pat_map(input logic [1:0] idx);
`ifdef PAIR_STIM_SEQ_GRAY_EN
        return idx ^ {1'b0, idx[1]};
`else
        return idx;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            pat_idx    <= '0;
            pass_idx   <= '0;
            in1        <= 1'b0;
            in2        <= 1'b0;
            sample_stb <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            pat_idx    <= '0;
            pass_idx   <= '0;
            in1        <= 1'b0;
            in2        <= 1'b0;
            sample_stb <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    sample_stb <= 1'b0;
                    if (start) begin
                        state      <= HOLD;
                        hold_cnt   <= '0;
                        pat_idx    <= 2'd0;
                        pass_idx   <= '0;
                        {in1, in2} <= pat_map(2'd0);
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= SAMPLE;
                        sample_stb <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                SAMPLE: begin
                    sample_stb <= 1'b0;
                    hold_cnt   <= '0;
                    if (pat_idx != 2'd3) begin
                        state      <= HOLD;
                        pat_idx    <= pat_idx + 2'd1;
                        {in1, in2} <= pat_map(pat_idx + 2'd1);
                    end else if (pass_idx != PASS_LAST) begin
                        state      <= HOLD;
                        pat_idx    <= 2'd0;
                        pass_idx   <= pass_idx + PASS_ONE;
                        {in1, in2} <= pat_map(2'd0);
                    end else begin
                        // Last pattern stays on the pins while parked in DONE.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_stim_seq.sv
// Bench for pair_stim_seq: two instances (H=2,R=1 and H=1,R=2) checked against a timeline model.
module tb_pair_stim_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, abort_a, start_b, abort_b;
    logic in1_a, in2_a, stb_a, busy_a, done_a;
    logic in1_b, in2_b, stb_b, busy_b, done_b;
    logic [1:0] pat_a, pat_b;
    logic [3:0] pass_a, pass_b;
    logic [10:0] act_a, act_b;

    int checks = 0;
    int failures = 0;

    int ma_mode = 0, ma_t = 0, mb_mode = 0, mb_t = 0;

    always #5 clk = ~clk;

    pair_stim_seq #(.HOLD_CYCLES(2), .HOLD_W(8), .REPEAT(1), .PASS_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .in1(in1_a), .in2(in2_a), .sample_stb(stb_a), .pat_idx(pat_a),
        .pass_idx(pass_a), .busy(busy_a), .done(done_a)
    );

    pair_stim_seq #(.HOLD_CYCLES(1), .HOLD_W(8), .REPEAT(2), .PASS_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .in1(in1_b), .in2(in2_b), .sample_stb(stb_b), .pat_idx(pat_b),
        .pass_idx(pass_b), .busy(busy_b), .done(done_b)
    );

    assign act_a = {in1_a, in2_a, stb_a, pat_a, pass_a, busy_a, done_a};
    assign act_b = {in1_b, in2_b, stb_b, pat_b, pass_b, busy_b, done_b};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int map_pat(input int p);
`ifdef PAIR_STIM_SEQ_GRAY_EN
        return p ^ (p >> 1);
`else
        return p;
`endif
    endfunction

    // Model: mode 0=idle, 1=running (t = cycles since launch, 1-based), 2=finished.
    function automatic int nxt_mode(input int mode, input int t, input logic st, input logic ab, input int total);
        if (ab) return 0;
        if (mode != 1 && st) return 1;
        if (mode == 1 && t == total) return 2;
        return mode;
    endfunction

    function automatic int nxt_t(input int mode, input int t, input logic st, input logic ab, input int total);
        if (ab) return 0;
        if (mode != 1 && st) return 1;
        if (mode == 1 && t < total) return t + 1;
        return t;
    endfunction

    function automatic logic [10:0] exp_vec(input int mode, input int t, input int h, input int r);
        int k, p, pos, pat, pass, v;
        v = 0;
        if (mode == 1) begin
            k    = t - 1;
            p    = k / (h + 1);
            pos  = k % (h + 1);
            pat  = p % 4;
            pass = p / 4;
            v = (map_pat(pat) << 9) | ((pos == h ? 1 : 0) << 8) | (pat << 6) | (pass << 2) | 2;
        end else if (mode == 2) begin
            v = (map_pat(3) << 9) | (3 << 6) | ((r - 1) << 2) | 1;
        end
        return 11'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_mode <= 0; ma_t <= 0; mb_mode <= 0; mb_t <= 0;
        end else begin
            ma_mode <= nxt_mode(ma_mode, ma_t, start_a, abort_a, 12);
            ma_t    <= nxt_t(ma_mode, ma_t, start_a, abort_a, 12);
            mb_mode <= nxt_mode(mb_mode, mb_t, start_b, abort_b, 16);
            mb_t    <= nxt_t(mb_mode, mb_t, start_b, abort_b, 16);
        end
    end

    always @(negedge clk) begin
        chk("model_a", 16'(act_a), 16'(exp_vec(ma_mode, ma_t, 2, 1)));
        chk("model_b", 16'(act_b), 16'(exp_vec(mb_mode, mb_t, 1, 2)));
    end

`ifdef PAIR_STIM_SEQ_GRAY_EN
    int lit_in[15] = '{0, 0, 0, 0, 1, 1, 1, 3, 3, 3, 2, 2, 2, 2, 2};
`else
    int lit_in[15] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3};
`endif
    int lit_stb[15] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    int lit_b_pat[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int lit_b_pass[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    // Start A at cycle 0, optionally pulse start again at restart_at, check cycles 1..14.
    task automatic run_lit(input int restart_at);
        logic [4:0] e;
        logic [1:0] prev, cur;
        prev = 2'b00;
        @(posedge clk); #1 start_a = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1 start_a = (c == restart_at);
            @(negedge clk);
            e = {2'(lit_in[c]), 1'(lit_stb[c]), (c >= 1 && c <= 12), (c >= 13)};
            chk("lit_seq", 16'({in1_a, in2_a, stb_a, busy_a, done_a}), 16'(e));
            cur = {in1_a, in2_a};
`ifdef PAIR_STIM_SEQ_GRAY_EN
            if (c > 1 && cur != prev) chk("gray_step", 16'($countones(cur ^ prev)), 16'd1);
`endif
            prev = cur;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_a", 16'(act_a), 16'd0);
        chk("reset_b", 16'(act_b), 16'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic sequence, then relaunch straight from DONE.
        run_lit(-1);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        @(negedge clk);
        chk("relaunch", 16'({busy_a, done_a, in1_a, in2_a}), 16'b1000);
        @(posedge clk); #1 abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;

        // Start pulsed while busy must not disturb timing.
        run_lit(4);
        @(posedge clk); #1 abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;

        // Abort in the cycle after strobe 2 (strobe 2 is cycle 6).
        @(posedge clk); #1 start_a = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1 start_a = 1'b0; abort_a = (c == 7);
            @(negedge clk);
            if (c == 8) chk("abort_idle", 16'(act_a), 16'd0);
        end
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stb_a) n++;
        end
        chk("abort_no_stb", 16'(n), 16'd0);

        // Async reset in the middle of a HOLD phase.
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        @(posedge clk); #3;
        chk("busy_before_rst", 16'(busy_a), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 16'(act_a), 16'd0);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        run_lit(-1);

        // Instance B: two passes, one-cycle hold.
        n = 0;
        @(posedge clk); #1 start_b = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk); #1 start_b = 1'b0;
            @(negedge clk);
            if (stb_b) begin
                if (n < 8) begin
                    chk("b_pat", 16'(pat_b), 16'(lit_b_pat[n]));
                    chk("b_pass", 16'(pass_b), 16'(lit_b_pass[n]));
                end
                n++;
            end
            chk("b_done", 16'(done_b), 16'(c >= 17));
        end
        chk("b_strobes", 16'(n), 16'd8);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
